// File: rtl/d_dest_if.sv
// Decode-stage bundle between the D pipeline register, the register file
// and the forwarding muxes, as seen by the destination scoreboard.
interface d_dest_if #(
    parameter int REG_W = 4,
    parameter int DEPTH = 3
);
    localparam int SEL_W = $clog2(2*DEPTH+1);

    logic [3:0]          D_icode;
    logic [REG_W-1:0]    D_rA;
    logic [REG_W-1:0]    D_rB;
    logic                D_valid;
    logic                E_bubble;
    logic                e_Cnd;

    logic [REG_W-1:0]    d_srcA;
    logic [REG_W-1:0]    d_srcB;
    logic [REG_W-1:0]    d_dstE;
    logic [REG_W-1:0]    d_dstM;
    logic [SEL_W-1:0]    fwdA_sel;
    logic [SEL_W-1:0]    fwdB_sel;
    logic                stall;
    logic [2**REG_W-1:0] busy_vec;

    // Pipeline side: presents the D-stage instruction, consumes decode results
    modport master (
        output D_icode, D_rA, D_rB, D_valid, E_bubble, e_Cnd,
        input  d_srcA, d_srcB, d_dstE, d_dstM, fwdA_sel, fwdB_sel, stall, busy_vec
    );

    // Scoreboard side
    modport slave (
        input  D_icode, D_rA, D_rB, D_valid, E_bubble, e_Cnd,
        output d_srcA, d_srcB, d_dstE, d_dstM, fwdA_sel, fwdB_sel, stall, busy_vec
    );
endinterface

// File: rtl/d_dest_scoreboard.sv
// Y86-64 decode register-ID generator plus a shadow of the dstE/dstM of the
// instructions in the DEPTH stages after decode. Produces forwarding selects,
// the load-use stall and a per-register pending-write vector.
// Forwarding select encoding: slot 2s-1 = stage s dstE, slot 2s = stage s dstM,
// 0 = register file.
module d_dest_scoreboard #(
    parameter int REG_W = 4,
    parameter int DEPTH = 3,
    parameter int RSP   = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    d_dest_if.slave bus
);
    localparam int               SEL_W  = $clog2(2*DEPTH+1);
    localparam int               NREG   = 2**REG_W;
    localparam logic [REG_W-1:0] RNONE  = {REG_W{1'b1}};
    localparam logic [REG_W-1:0] RSP_ID = REG_W'(RSP);

    logic [REG_W-1:0] src_a, src_b, dst_e, dst_m;

    logic             valid_q [DEPTH];
    logic [3:0]       icode_q [DEPTH];
    logic [REG_W-1:0] dste_q  [DEPTH];
    logic [REG_W-1:0] dstm_q  [DEPTH];
    logic [REG_W-1:0] eff_dste[DEPTH];

    logic             valid_d;
    logic [3:0]       icode_d;
    logic [REG_W-1:0] dste_d, dstm_d;

    logic             stall;
    logic [NREG-1:0]  busy;

    // Register-ID decode from the D-stage instruction
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        if (bus.D_valid) begin
            case (bus.D_icode)
                4'h2: begin src_a = bus.D_rA; dst_e = bus.D_rB; end
                4'h3: begin dst_e = bus.D_rB; end
                4'h4: begin src_a = bus.D_rA; src_b = bus.D_rB; end
                4'h5: begin src_b = bus.D_rB; dst_m = bus.D_rA; end
                4'h6: begin src_a = bus.D_rA; src_b = bus.D_rB; dst_e = bus.D_rB; end
                4'h8: begin src_b = RSP_ID; dst_e = RSP_ID; end
                4'h9: begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID; end
                4'hA: begin src_a = bus.D_rA; src_b = RSP_ID; dst_e = RSP_ID; end
                4'hB: begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID; dst_m = bus.D_rA; end
                default: ;
            endcase
        end
    end

    // Effective dstE: a not-taken cmov in stage 1 writes nothing
    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            eff_dste[s] = dste_q[s];
        end
        if (icode_q[0] == 4'h2 && !bus.e_Cnd) begin
            eff_dste[0] = RNONE;
        end
    end

    // Load-use: a load in stage 1 whose dstM feeds a source in decode
    always_comb begin
        stall = 1'b0;
        if (valid_q[0] && (icode_q[0] == 4'h5 || icode_q[0] == 4'hB) && dstm_q[0] != RNONE) begin
            if ((src_a != RNONE && dstm_q[0] == src_a) ||
                (src_b != RNONE && dstm_q[0] == src_b)) begin
                stall = 1'b1;
            end
        end
    end

    // Stage-1 next state: decoded instruction or a bubble
    always_comb begin
        valid_d = 1'b0;
        icode_d = 4'h0;
        dste_d  = RNONE;
        dstm_d  = RNONE;
        if (bus.D_valid && !stall && !bus.E_bubble) begin
            valid_d = 1'b1;
            icode_d = bus.D_icode;
            dste_d  = dst_e;
            dstm_d  = dst_m;
        end
    end

    // Slot shift register; the last stage retires off the end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                valid_q[s] <= 1'b0;
                icode_q[s] <= 4'h0;
                dste_q[s]  <= RNONE;
                dstm_q[s]  <= RNONE;
            end
        end else begin
            valid_q[0] <= valid_d;
            icode_q[0] <= icode_d;
            dste_q[0]  <= dste_d;
            dstm_q[0]  <= dstm_d;
            for (int s = 1; s < DEPTH; s++) begin
                valid_q[s] <= valid_q[s-1];
                icode_q[s] <= icode_q[s-1];
                dste_q[s]  <= eff_dste[s-1];
                dstm_q[s]  <= dstm_q[s-1];
            end
        end
    end

    // Walk slots from lowest to highest priority so the highest match is left standing
    function automatic logic [SEL_W-1:0] fwd_sel(input logic [REG_W-1:0] src);
        logic [SEL_W-1:0] sel;
        sel = '0;
        if (src != RNONE) begin
            for (int s = DEPTH-1; s >= 1; s--) begin
                if (valid_q[s] && eff_dste[s] == src) sel = SEL_W'(2*s+1);
                if (valid_q[s] && dstm_q[s] == src)   sel = SEL_W'(2*s+2);
            end
            if (valid_q[0] && eff_dste[0] == src) sel = SEL_W'(1);
        end
        return sel;
    endfunction

    // Pending-write vector; the RNONE bit absorbs empty destinations and is cleared
    always_comb begin
        busy = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (valid_q[s]) begin
                busy[eff_dste[s]] = 1'b1;
                busy[dstm_q[s]]   = 1'b1;
            end
        end
        busy[RNONE] = 1'b0;
    end

    assign bus.d_srcA   = src_a;
    assign bus.d_srcB   = src_b;
    assign bus.d_dstE   = dst_e;
    assign bus.d_dstM   = dst_m;
    assign bus.fwdA_sel = fwd_sel(src_a);
    assign bus.fwdB_sel = fwd_sel(src_b);
    assign bus.stall    = stall;
    assign bus.busy_vec = busy;
endmodule

// File: tb/tb_d_dest_scoreboard.sv
// Directed bench for d_dest_scoreboard with REG_W=4, DEPTH=3, RSP=4.
module tb_d_dest_scoreboard;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    d_dest_if #(.REG_W(4), .DEPTH(3)) bus ();

    d_dest_scoreboard #(.REG_W(4), .DEPTH(3), .RSP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb);
        bus.D_icode = icode;
        bus.D_rA    = ra;
        bus.D_rB    = rb;
        bus.D_valid = 1'b1;
        #1;
    endtask

    task automatic flush();
        bus.D_valid  = 1'b0;
        bus.E_bubble = 1'b0;
        bus.e_Cnd    = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.E_bubble = 1'b0;
        bus.e_Cnd = 1'b1;
        drive(4'h6, 4'h0, 4'h3);
        #3;
        checks++; if (bus.d_srcA !== 4'h0) begin errors++; $display("FAIL reset_srcA got=%0h want=0", bus.d_srcA); end
        checks++; if (bus.d_srcB !== 4'h3) begin errors++; $display("FAIL reset_srcB got=%0h want=3", bus.d_srcB); end
        checks++; if (bus.d_dstE !== 4'h3) begin errors++; $display("FAIL reset_dstE got=%0h want=3", bus.d_dstE); end
        checks++; if (bus.d_dstM !== 4'hF) begin errors++; $display("FAIL reset_dstM got=%0h want=f", bus.d_dstM); end
        checks++; if (bus.fwdA_sel !== 3'd0 || bus.fwdB_sel !== 3'd0) begin errors++; $display("FAIL reset_fwd got=%0d/%0d want=0/0", bus.fwdA_sel, bus.fwdB_sel); end
        checks++; if (bus.stall !== 1'b0 || bus.busy_vec !== 16'h0) begin errors++; $display("FAIL reset_stall_busy got=%0b/%h want=0/0000", bus.stall, bus.busy_vec); end
        @(negedge clk);
        rst_n = 1'b1;
        flush();
    endtask

    task automatic test_decode();
        flush();
        drive(4'hB, 4'h3, 4'hF);
        checks++; if ({bus.d_srcA, bus.d_srcB, bus.d_dstE, bus.d_dstM} !== 16'h4443) begin errors++; $display("FAIL decode_popq got=%h want=4443", {bus.d_srcA, bus.d_srcB, bus.d_dstE, bus.d_dstM}); end
        drive(4'h8, 4'hF, 4'hF);
        checks++; if ({bus.d_srcA, bus.d_srcB, bus.d_dstE, bus.d_dstM} !== 16'hF44F) begin errors++; $display("FAIL decode_call got=%h want=f44f", {bus.d_srcA, bus.d_srcB, bus.d_dstE, bus.d_dstM}); end
        drive(4'hA, 4'h7, 4'hF);
        checks++; if ({bus.d_srcA, bus.d_srcB, bus.d_dstE, bus.d_dstM} !== 16'h744F) begin errors++; $display("FAIL decode_pushq got=%h want=744f", {bus.d_srcA, bus.d_srcB, bus.d_dstE, bus.d_dstM}); end
        drive(4'h6, 4'h1, 4'h2);
        bus.D_valid = 1'b0;
        #1;
        checks++; if ({bus.d_srcA, bus.d_srcB, bus.d_dstE, bus.d_dstM} !== 16'hFFFF) begin errors++; $display("FAIL decode_invalid got=%h want=ffff", {bus.d_srcA, bus.d_srcB, bus.d_dstE, bus.d_dstM}); end
    endtask

    task automatic test_forward_alu();
        flush();
        drive(4'h3, 4'hF, 4'h0);
        step();
        drive(4'h6, 4'h0, 4'h3);
        checks++; if (bus.fwdA_sel !== 3'd1) begin errors++; $display("FAIL alu_fwdA_s1 got=%0d want=1", bus.fwdA_sel); end
        checks++; if (bus.fwdB_sel !== 3'd0) begin errors++; $display("FAIL alu_fwdB_s1 got=%0d want=0", bus.fwdB_sel); end
        checks++; if (bus.busy_vec[0] !== 1'b1 || bus.stall !== 1'b0) begin errors++; $display("FAIL alu_busy0 got=%0b/%0b want=1/0", bus.busy_vec[0], bus.stall); end
        step();
        drive(4'h2, 4'h0, 4'h1);
        checks++; if (bus.fwdA_sel !== 3'd3) begin errors++; $display("FAIL alu_fwdA_s2 got=%0d want=3", bus.fwdA_sel); end
        step();
        checks++; if (bus.fwdA_sel !== 3'd5) begin errors++; $display("FAIL alu_fwdA_s3 got=%0d want=5", bus.fwdA_sel); end
        checks++; if (bus.busy_vec !== 16'h000B) begin errors++; $display("FAIL alu_busy_vec got=%h want=000b", bus.busy_vec); end
    endtask

    task automatic test_load_use();
        flush();
        drive(4'h5, 4'h3, 4'h1);
        step();
        drive(4'h6, 4'h3, 4'h2);
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0b want=1", bus.stall); end
        checks++; if (bus.fwdA_sel !== 3'd0 || bus.busy_vec[3] !== 1'b1) begin errors++; $display("FAIL lu_fwdA_busy got=%0d/%0b want=0/1", bus.fwdA_sel, bus.busy_vec[3]); end
        step();
        checks++; if (bus.stall !== 1'b0 || bus.fwdA_sel !== 3'd4) begin errors++; $display("FAIL lu_after got=%0b/%0d want=0/4", bus.stall, bus.fwdA_sel); end
        step();
        checks++; if (bus.stall !== 1'b0 || bus.fwdA_sel !== 3'd6) begin errors++; $display("FAIL lu_stage3 got=%0b/%0d want=0/6", bus.stall, bus.fwdA_sel); end
        flush();
        drive(4'h5, 4'h3, 4'h1);
        step();
        drive(4'h4, 4'h0, 4'h3);
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_srcB_stall got=%0b want=1", bus.stall); end
        bus.E_bubble = 1'b1;
        step();
        bus.E_bubble = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0 || bus.fwdB_sel !== 3'd4) begin errors++; $display("FAIL lu_srcB_after got=%0b/%0d want=0/4", bus.stall, bus.fwdB_sel); end
    endtask

    task automatic test_cmov();
        flush();
        drive(4'h2, 4'h0, 4'h6);
        step();
        bus.e_Cnd = 1'b1;
        #1;
        checks++; if (bus.busy_vec[6] !== 1'b1) begin errors++; $display("FAIL cmov_taken_busy got=%0b want=1", bus.busy_vec[6]); end
        bus.e_Cnd = 1'b0;
        drive(4'h6, 4'h6, 4'h7);
        checks++; if (bus.fwdA_sel !== 3'd0 || bus.busy_vec[6] !== 1'b0) begin errors++; $display("FAIL cmov_cancel_s1 got=%0d/%0b want=0/0", bus.fwdA_sel, bus.busy_vec[6]); end
        step();
        bus.e_Cnd = 1'b1;
        #1;
        checks++; if (bus.fwdA_sel !== 3'd0 || bus.busy_vec[6] !== 1'b0) begin errors++; $display("FAIL cmov_cancel_s2 got=%0d/%0b want=0/0", bus.fwdA_sel, bus.busy_vec[6]); end
        checks++; if (bus.busy_vec[7] !== 1'b1) begin errors++; $display("FAIL cmov_next_busy7 got=%0b want=1", bus.busy_vec[7]); end
    endtask

    task automatic test_pop_rsp();
        flush();
        drive(4'hB, 4'h4, 4'hF);
        step();
        drive(4'h1, 4'hF, 4'hF);
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL pop_nop_stall got=%0b want=0", bus.stall); end
        step();
        drive(4'h2, 4'h4, 4'h0);
        checks++; if (bus.fwdA_sel !== 3'd4 || bus.fwdB_sel !== 3'd0) begin errors++; $display("FAIL pop_fwd got=%0d/%0d want=4/0", bus.fwdA_sel, bus.fwdB_sel); end
        checks++; if (bus.busy_vec[4] !== 1'b1) begin errors++; $display("FAIL pop_busy4 got=%0b want=1", bus.busy_vec[4]); end
    endtask

    task automatic test_bubble();
        flush();
        drive(4'h3, 4'hF, 4'h8);
        bus.E_bubble = 1'b1;
        step();
        bus.E_bubble = 1'b0;
        drive(4'h2, 4'h8, 4'h0);
        checks++; if (bus.fwdA_sel !== 3'd0 || bus.busy_vec[8] !== 1'b0) begin errors++; $display("FAIL bubble_s1 got=%0d/%0b want=0/0", bus.fwdA_sel, bus.busy_vec[8]); end
        step();
        checks++; if (bus.fwdA_sel !== 3'd0) begin errors++; $display("FAIL bubble_s2 got=%0d want=0", bus.fwdA_sel); end
    endtask

    task automatic test_reset_mid();
        flush();
        drive(4'h3, 4'hF, 4'h3);
        step();
        drive(4'h5, 4'h3, 4'h1);
        step();
        drive(4'h6, 4'h3, 4'h2);
        checks++; if (bus.stall !== 1'b1 || bus.busy_vec !== 16'h0008) begin errors++; $display("FAIL rmid_before got=%0b/%h want=1/0008", bus.stall, bus.busy_vec); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0 || bus.busy_vec !== 16'h0) begin errors++; $display("FAIL rmid_stall_busy got=%0b/%h want=0/0000", bus.stall, bus.busy_vec); end
        checks++; if (bus.fwdA_sel !== 3'd0 || bus.fwdB_sel !== 3'd0) begin errors++; $display("FAIL rmid_fwd got=%0d/%0d want=0/0", bus.fwdA_sel, bus.fwdB_sel); end
        @(negedge clk);
        rst_n = 1'b1;
        flush();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.D_icode = 4'h0;
        bus.D_rA = 4'hF;
        bus.D_rB = 4'hF;
        bus.D_valid = 1'b0;
        bus.E_bubble = 1'b0;
        bus.e_Cnd = 1'b1;
        #2;
        test_reset();
        test_decode();
        test_forward_alu();
        test_load_use();
        test_cmov();
        test_pop_rsp();
        test_bubble();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
